// File: rtl/rfdc_multi_channel_sequencer_pkg.sv
// Shared types, widths and helpers for the multi-channel DAC sequencer.
// Datapath widths are fixed here to match the RFDC tile configuration;
// lane count and FIFO depth are parameters of the top module.
package rfdc_seq_pkg;

  localparam int TS_WIDTH         = 64;
  localparam int DATA_WIDTH       = 64;
  localparam int AXIS_DATA_WIDTH  = 256;
  localparam int SAMPLES_PER_BEAT = AXIS_DATA_WIDTH / DATA_WIDTH;
  localparam int ENTRY_WIDTH      = TS_WIDTH + DATA_WIDTH;

  // Timestamp sits in the MSBs of the write word.
  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] payload;
  } entry_t;

  // Bit positions of the per-lane sticky error vector.
  localparam int ERR_LATE     = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_UNDERRUN = 2;
  localparam int ERR_NUM      = 3;

  // Arming state shared by all lanes.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Fill a full DAC beat with copies of one payload sample.
  function automatic logic [AXIS_DATA_WIDTH-1:0] replicate_sample(
    input logic [DATA_WIDTH-1:0] payload
  );
    return {SAMPLES_PER_BEAT{payload}};
  endfunction

endpackage

// File: rtl/rfdc_multi_channel_sequencer_if.sv
// Shared write port plus the per-lane DAC AXIS streams.
// master = the upstream bridge / RFDC side, slave = the sequencer.
interface rfdc_multi_channel_sequencer_if
  import rfdc_seq_pkg::*;
#(
  parameter int NUM_CH = 4
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                              wr_en;
  logic [CH_W-1:0]                   wr_ch;
  logic [ENTRY_WIDTH-1:0]            wr_data;
  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [NUM_CH-1:0]                 m_axis_tvalid;
  logic [NUM_CH-1:0]                 m_axis_tready;

  modport master (
    output wr_en, wr_ch, wr_data, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/rfdc_multi_channel_sequencer_lane.sv
// One timed-command lane: entry FIFO, release / late-discard decision,
// held DAC sample register and sticky error flags.
module rfdc_seq_lane
  import rfdc_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run,
  input  logic [TS_WIDTH-1:0]        i_counter,
  input  logic                       i_wr_en,
  input  entry_t                     i_wr_entry,
  input  logic                       i_flush,
  input  logic                       i_err_clr,
  input  logic                       i_tready,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [LVL_W-1:0]           o_level,
  output logic [AXIS_DATA_WIDTH-1:0] o_tdata,
  output logic                       o_matched,
  output logic                       o_ts_err,
  output logic                       o_ovf_err,
  output logic                       o_und_err,
  output logic [TS_WIDTH-1:0]        o_error_data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Head must be compared in the same cycle it is presented, so the
  // storage is read asynchronously (distributed RAM rather than BRAM).
  entry_t                     r_mem [DEPTH];
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [LVL_W-1:0]           r_level;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata;
  logic                       r_matched;
  logic [ERR_NUM-1:0]         r_err;
  logic [TS_WIDTH-1:0]        r_error_data;

  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop_ok;
  logic               w_release;
  logic               w_late;
  logic               w_pop;
  logic               w_push;
  logic [ERR_NUM-1:0] w_err_set;

  assign w_head    = r_mem[r_rptr];
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  // Flush wins over a pop and silently swallows a same-cycle write.
  assign w_pop_ok  = i_run & ~w_empty & ~i_flush;
  assign w_release = w_pop_ok & (w_head.ts == i_counter);
  assign w_late    = w_pop_ok & (w_head.ts <  i_counter);
  assign w_pop     = w_release | w_late;
  assign w_push    = i_wr_en & ~w_full & ~i_flush;

  // Error events this cycle; full uses the pre-cycle level even if a pop happens.
  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_LATE]     = w_late;
    w_err_set[ERR_OVERFLOW] = i_wr_en & w_full & ~i_flush;
    w_err_set[ERR_UNDERRUN] = i_run & ~i_tready;
  end

  // Entry storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wr_entry;
    end
  end

  // Pointers wrap naturally; level tracks occupancy for full/empty.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Held DAC sample, release pulse, sticky flags (set beats clear) and late timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata      <= '0;
      r_matched    <= 1'b0;
      r_err        <= '0;
      r_error_data <= '0;
    end else begin
      r_matched <= w_release;
      if (w_release) r_tdata <= replicate_sample(w_head.payload);
      if (w_late)    r_error_data <= w_head.ts;
      r_err <= w_err_set | (r_err & {ERR_NUM{~i_err_clr}});
    end
  end

  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_level      = r_level;
  assign o_tdata      = r_tdata;
  assign o_matched    = r_matched;
  assign o_ts_err     = r_err[ERR_LATE];
  assign o_ovf_err    = r_err[ERR_OVERFLOW];
  assign o_und_err    = r_err[ERR_UNDERRUN];
  assign o_error_data = r_error_data;

endmodule

// File: rtl/rfdc_multi_channel_sequencer.sv
// NUM_CH timed-command lanes behind one shared write port. Holds the write
// demux, the auto_start arming FSM and the packing of per-lane outputs.
module rfdc_multi_channel_sequencer
  import rfdc_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TS_WIDTH-1:0]        counter,
  input  logic                       auto_start,
  rfdc_multi_channel_sequencer_if.slave bus,
  input  logic [NUM_CH-1:0]          flush,
  input  logic [NUM_CH-1:0]          err_clr,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          empty,
  output logic [NUM_CH*LVL_W-1:0]    level,
  output logic [NUM_CH-1:0]          counter_matched,
  output logic [NUM_CH-1:0]          timestamp_error,
  output logic [NUM_CH-1:0]          overflow_error,
  output logic [NUM_CH-1:0]          underrun_error,
  output logic [NUM_CH*TS_WIDTH-1:0] error_data
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  run_state_t                        r_state;
  run_state_t                        w_state_next;
  logic                              r_auto_start_prev;
  logic                              w_run;
  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] w_tdata;

  // Arming state and the previous auto_start sample for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_auto_start_prev <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_auto_start_prev <= auto_start;
    end
  end

  // A rising auto_start arms all lanes; only reset disarms.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && auto_start && !r_auto_start_prev) begin
      w_state_next = ST_RUN;
    end
  end

  assign w_run = (r_state == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic w_lane_wr;
      // Writes addressed beyond the last lane match nothing and vanish.
      assign w_lane_wr = bus.wr_en && (bus.wr_ch == CH_W'(gi));

      rfdc_seq_lane #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
      ) u_lane (
        .clk          (clk),
        .reset        (reset),
        .i_run        (w_run),
        .i_counter    (counter),
        .i_wr_en      (w_lane_wr),
        .i_wr_entry   (entry_t'(bus.wr_data)),
        .i_flush      (flush[gi]),
        .i_err_clr    (err_clr[gi]),
        .i_tready     (bus.m_axis_tready[gi]),
        .o_full       (full[gi]),
        .o_empty      (empty[gi]),
        .o_level      (level[gi*LVL_W +: LVL_W]),
        .o_tdata      (w_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]),
        .o_matched    (counter_matched[gi]),
        .o_ts_err     (timestamp_error[gi]),
        .o_ovf_err    (overflow_error[gi]),
        .o_und_err    (underrun_error[gi]),
        .o_error_data (error_data[gi*TS_WIDTH +: TS_WIDTH])
      );
    end
  endgenerate

  // Once armed every stream is continuously valid.
  assign bus.m_axis_tdata  = w_tdata;
  assign bus.m_axis_tvalid = {NUM_CH{w_run}};

endmodule

// File: tb/tb_rfdc_multi_channel_sequencer.sv
// Randomised plus directed bench for the multi-channel sequencer, checked
// every cycle against a queue-based reference model of the lane rules.
module tb_rfdc_multi_channel_sequencer;
  import rfdc_seq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = 5;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [63:0]                counter;
  logic                       auto_start;
  logic [NUM_CH-1:0]          flush;
  logic [NUM_CH-1:0]          err_clr;
  logic [NUM_CH-1:0]          full;
  logic [NUM_CH-1:0]          empty;
  logic [NUM_CH*LVL_W-1:0]    level;
  logic [NUM_CH-1:0]          counter_matched;
  logic [NUM_CH-1:0]          timestamp_error;
  logic [NUM_CH-1:0]          overflow_error;
  logic [NUM_CH-1:0]          underrun_error;
  logic [NUM_CH*64-1:0]       error_data;

  rfdc_multi_channel_sequencer_if #(.NUM_CH(NUM_CH)) bus();

  rfdc_multi_channel_sequencer #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .counter         (counter),
    .auto_start      (auto_start),
    .bus             (bus),
    .flush           (flush),
    .err_clr         (err_clr),
    .full            (full),
    .empty           (empty),
    .level           (level),
    .counter_matched (counter_matched),
    .timestamp_error (timestamp_error),
    .overflow_error  (overflow_error),
    .underrun_error  (underrun_error),
    .error_data      (error_data)
  );

  always #5 clk = ~clk;

  // Reference model: one queue of {ts, payload} per lane plus visible state.
  logic [127:0] mq [NUM_CH][$];
  logic [63:0]  m_payload [NUM_CH];
  logic [63:0]  m_edata   [NUM_CH];
  bit           m_matched [NUM_CH];
  bit           m_terr    [NUM_CH];
  bit           m_ovf     [NUM_CH];
  bit           m_und     [NUM_CH];
  bit           m_run;
  bit           m_prev;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit arm;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        m_payload[c] = '0; m_edata[c] = '0;
        m_matched[c] = 0; m_terr[c] = 0; m_ovf[c] = 0; m_und[c] = 0;
      end
      m_run  = 0;
      m_prev = 0;
      return;
    end
    arm = auto_start && !m_prev;
    for (int c = 0; c < NUM_CH; c++) begin
      bit set_late, set_ovf, set_und;
      int old_size;
      logic [127:0] h;
      set_late = 0; set_ovf = 0; set_und = 0;
      old_size = mq[c].size();
      m_matched[c] = 0;
      if (m_run && old_size > 0 && !flush[c]) begin
        h = mq[c][0];
        if (h[127:64] == counter) begin
          m_payload[c] = h[63:0];
          m_matched[c] = 1;
          void'(mq[c].pop_front());
        end else if (h[127:64] < counter) begin
          set_late = 1;
          m_edata[c] = h[127:64];
          void'(mq[c].pop_front());
        end
      end
      if (bus.wr_en && int'(bus.wr_ch) == c && !flush[c]) begin
        if (old_size == DEPTH) set_ovf = 1;
        else mq[c].push_back(bus.wr_data);
      end
      if (flush[c]) mq[c].delete();
      if (m_run && !bus.m_axis_tready[c]) set_und = 1;
      m_terr[c] = set_late || (m_terr[c] && !err_clr[c]);
      m_ovf[c]  = set_ovf  || (m_ovf[c]  && !err_clr[c]);
      m_und[c]  = set_und  || (m_und[c]  && !err_clr[c]);
    end
    m_run  = m_run || arm;
    m_prev = auto_start;
  endtask

  task automatic compare_all();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("level[%0d]", c), 256'(level[c*LVL_W +: LVL_W]), 256'(mq[c].size()));
      check($sformatf("full[%0d]", c),  256'(full[c]),  256'(mq[c].size() == DEPTH));
      check($sformatf("empty[%0d]", c), 256'(empty[c]), 256'(mq[c].size() == 0));
      check($sformatf("tdata[%0d]", c), bus.m_axis_tdata[c*256 +: 256], {4{m_payload[c]}});
      check($sformatf("tvalid[%0d]", c), 256'(bus.m_axis_tvalid[c]), 256'(m_run));
      check($sformatf("matched[%0d]", c), 256'(counter_matched[c]), 256'(m_matched[c]));
      check($sformatf("ts_err[%0d]", c), 256'(timestamp_error[c]), 256'(m_terr[c]));
      check($sformatf("ovf_err[%0d]", c), 256'(overflow_error[c]), 256'(m_ovf[c]));
      check($sformatf("und_err[%0d]", c), 256'(underrun_error[c]), 256'(m_und[c]));
      check($sformatf("err_data[%0d]", c), 256'(error_data[c*64 +: 64]), 256'(m_edata[c]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input int ch, input logic [63:0] ts, input logic [63:0] p);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_data = {ts, p};
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic arm();
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; counter = '0; auto_start = 1'b0;
    flush = '0; err_clr = '0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    bus.m_axis_tready = '1;

    // Reset state and timed release on lane 1, late discard on lane 0.
    do_reset();
    check("rst_empty", 256'(empty), 256'(4'hF));
    wr(1, 64'd100, 64'hA);
    wr(1, 64'd105, 64'hB);
    wr(0, 64'd10, 64'h5);
    counter = 64'd20;
    arm();
    for (int t = 21; t <= 110; t++) begin
      counter = 64'(t);
      tick();
    end
    check("s1_tdata1", bus.m_axis_tdata[511:256], {4{64'hB}});
    check("s1_edata0", 256'(error_data[63:0]), 256'd10);
    check("s1_tdata0", bus.m_axis_tdata[255:0], 256'd0);
    err_clr = 4'b0001;
    tick();
    err_clr = '0;
    check("s1_clr0", 256'(timestamp_error[0]), 256'd0);

    // Overflow on lane 2; full lane 3 with concurrent release and write.
    do_reset();
    counter = '0;
    for (int i = 0; i < DEPTH + 1; i++) wr(2, 64'(1000 + i), 64'(i));
    for (int i = 0; i < DEPTH; i++)     wr(3, 64'(200 + i), 64'(16'hC0 + i));
    check("s2_full", 256'(full), 256'(4'b1100));
    counter = 64'd190;
    arm();
    for (int t = 191; t < 200; t++) begin
      counter = 64'(t);
      tick();
    end
    counter = 64'd200;
    wr(3, 64'd999, 64'hDEAD);
    check("s2_lvl3", 256'(level[3*LVL_W +: LVL_W]), 256'd15);
    check("s2_ovf", 256'(overflow_error), 256'(4'b1100));
    check("s2_lvl2", 256'(level[2*LVL_W +: LVL_W]), 256'd16);

    // Flush with a concurrent write to the same lane.
    do_reset();
    for (int i = 0; i < 5; i++) wr(0, 64'(50 + i), 64'(i));
    flush = 4'b0001;
    wr(0, 64'd77, 64'h77);
    flush = '0;
    check("s3_lvl0", 256'(level[LVL_W-1:0]), 256'd0);
    check("s3_ovf", 256'(overflow_error[0]), 256'd0);

    // Underrun, then reset mid-stream and re-arm.
    do_reset();
    arm();
    tick();
    bus.m_axis_tready = 4'b1101;
    tick();
    bus.m_axis_tready = '1;
    check("s4_und1", 256'(underrun_error), 256'(4'b0010));
    bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_data = {64'd5, 64'h1};
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.wr_en = 1'b0;
    check("s4_tvalid_rst", 256'(bus.m_axis_tvalid), 256'd0);
    tick();
    arm();
    check("s4_rearm", 256'(bus.m_axis_tvalid), 256'(4'hF));

    // Randomised traffic against the model, including one mid-run reset.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      counter = 64'd20;
      for (int i = 0; i < 12; i++)
        wr($urandom_range(0, 3), 64'($urandom_range(10, 80)), 64'($urandom));
      arm();
      for (int cyc = 0; cyc < 1200; cyc++) begin
        counter = counter + 64'($urandom_range(0, 2));
        bus.wr_en   = ($urandom_range(0, 1) == 1);
        bus.wr_ch   = 2'($urandom_range(0, 3));
        bus.wr_data = {counter + 64'($urandom_range(0, 40)) - 64'd5, 32'($urandom), 32'($urandom)};
        for (int c = 0; c < NUM_CH; c++) begin
          flush[c]             = ($urandom_range(0, 63) == 0);
          err_clr[c]           = ($urandom_range(0, 15) == 0);
          bus.m_axis_tready[c] = ($urandom_range(0, 31) != 0);
        end
        tick();
      end
      bus.wr_en = 1'b0; flush = '0; err_clr = '0; bus.m_axis_tready = '1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfdc_multi_channel_sequencer.md
Name: rfdc_multi_channel_sequencer

Overview:
- Parametrised successor of the single-channel DAC timing path. NUM_CH independent timed-command lanes share one write port. Each lane buffers {timestamp, payload} entries and releases each payload when the global 64-bit counter reaches its timestamp.
- Each lane drives a continuous RFDC DAC AXIS stream that holds the last released sample. Late entries and FIFO overflows are flagged per lane.
- Sits between the AXI2FIFO bridge and the RFDC DAC tiles. Replaces a separate RTO_Core plus controller pair per DAC.

Parameters:
- NUM_CH, 4, number of DAC lanes
- DEPTH, 16, entries per lane FIFO; power of two, at least 2
- TS_WIDTH, 64, timestamp and counter width
- DATA_WIDTH, 64, payload width per entry
- AXIS_DATA_WIDTH, 256, DAC stream width; integer multiple of DATA_WIDTH
- LVL_W, $clog2(DEPTH+1), fill-level width

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high; clears all state
- counter  in  TS_WIDTH  global time from TimeController
- auto_start  in  1  rising edge arms all lanes
- wr_en  in  1  write strobe
- wr_ch  in  $clog2(NUM_CH)  target lane of the write
- wr_data  in  TS_WIDTH+DATA_WIDTH  {timestamp, payload}; timestamp in the MSBs
- flush  in  NUM_CH  per-lane FIFO flush mask
- err_clr  in  NUM_CH  per-lane clear for sticky errors
- full  out  NUM_CH  lane FIFO full
- empty  out  NUM_CH  lane FIFO empty
- level  out  NUM_CH*LVL_W  lane fill levels, packed
- m_axis_tdata  out  NUM_CH*AXIS_DATA_WIDTH  per-lane DAC samples
- m_axis_tvalid  out  NUM_CH  per-lane valid
- m_axis_tready  in  NUM_CH  per-lane ready from RFDC
- counter_matched  out  NUM_CH  one-cycle pulse per release
- timestamp_error  out  NUM_CH  sticky: late entry discarded
- overflow_error  out  NUM_CH  sticky: write to full lane dropped
- underrun_error  out  NUM_CH  sticky: tready low while tvalid high
- error_data  out  NUM_CH*TS_WIDTH  timestamp of the most recent late entry per lane

Behaviour:
- Reset values:
  - All FIFOs empty; level = 0; full = 0; empty = all 1.
  - tdata = 0; tvalid = 0; counter_matched = 0.
  - All error flags and error_data = 0.
  - run = 0.
- Arming: run is set one cycle after a rising edge of auto_start, detected with a registered previous value. run is cleared only by reset.
- tvalid[ch] = run. Once armed, the stream is continuous; tdata holds its value between releases.
- Write:
  - If wr_en and lane wr_ch is not full, the entry is pushed; level increments the next cycle.
  - If the lane is full, the write is dropped, overflow_error[ch] is set, and the FIFO is unchanged.
  - wr_ch >= NUM_CH: write ignored, no flag.
- Release (per lane, at most one pop per cycle):
  - Condition: run=1, not empty, head.ts == counter at cycle N.
  - Pop at N. tdata updates at N+1 with the payload replicated AXIS_DATA_WIDTH/DATA_WIDTH times. counter_matched pulses at N+1.
  - Latency is one cycle from counter equality to visible sample.
- Late entry:
  - Condition: run=1, not empty, head.ts < counter (unsigned).
  - Pop and discard. Set timestamp_error. Load error_data with head.ts. tdata is unchanged.
  - A backlog of late entries drains at one per cycle.
- Before run: no pops. Entries accumulate regardless of timestamps.
- Simultaneous push and pop on one lane: both happen; level is unchanged; full is evaluated on the pre-cycle level, so a push to a full lane with a concurrent pop is still dropped and flagged.
- Flush: flush[ch] empties the lane at the end of the cycle and overrides any pop. A write to the same lane in the same cycle is dropped without a flag. Sticky flags and tdata are not affected.
- err_clr[ch] clears that lane's three sticky flags. If a new error event occurs in the same cycle, set wins.
- underrun_error: set when tvalid=1 and tready=0. Data still advances; there is no backpressure to the FIFO.
- Pointers: log2(DEPTH) bits with wrap-around. full and empty are derived from a separate level counter.
- Reset mid-operation: all lanes return to the reset state on the next edge. In-flight writes are lost.

Decomposition:
- Package rfdc_seq_pkg: entry_t struct {ts, payload}; error-code constants; function replicate_sample.
- Sub-module rfdc_seq_lane: one FIFO, release/late logic, output register and flags. Instantiated NUM_CH times by a generate loop.
- The top level holds the write demux, auto_start edge detect and output packing.

Test Plan:
- Write lane 1 entries ts=100/p=0xA, ts=105/p=0xB; arm at counter=50; ramp counter -> tdata[1] = 0xA replicated from counter=101 and 0xB from 106; counter_matched[1] pulses twice; other lanes stay 0.
- Write ts=10 on lane 0; arm at counter=20 -> entry discarded; timestamp_error[0]=1; error_data[0]=10; tdata unchanged; err_clr[0] -> flag 0.
- Write DEPTH+1 entries to lane 2 -> full[2]=1 after DEPTH writes; 17th write dropped; overflow_error[2]=1; level[2]=16.
- Lane 3 full, write plus a release in the same cycle -> write dropped and flagged; level[3]=15.
- Flush lane 0 with 5 entries and a concurrent write -> level[0]=0 and empty[0]=1 next cycle; no flags.
- Armed, tready[1]=0 for one cycle -> underrun_error[1]=1; assert reset mid-stream -> all outputs at reset values; auto_start must re-arm.
